// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with flush; head reads as zero when empty
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  T              data,
    input  logic          pop,
    output T              head,
    output logic [CW-1:0] count
);

    T              mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_pop = pop && (count != '0);
    assign head   = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Writing the slot being popped is safe: the head is read before the edge.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= data;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - RISC-V fetch stage; FETCH_MISALIGN_CHECK_EN enables misaligned-redirect fault
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_instr,
    output logic [6:0]  o_opcode,
    output logic [31:0] o_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        o_fetch_fault
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   pc;
    logic [CW-1:0] drop;
    logic [CW-1:0] pend_cnt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] outs;
    logic [CW:0]   used;
    logic          halted;
    logic          req_fire;
    logic          rsp_live;
    logic          buf_pop;
    logic [31:0]   pend_pc;
    fetch_entry_t  buf_in;
    fetch_entry_t  buf_head;

    // Responses return in order, so squashed ones always precede live ones.
    assign outs     = drop + pend_cnt;
    assign used     = {1'b0, cnt} + {1'b0, outs};
    assign req_fire = o_imem_req_valid && i_imem_req_ready;
    assign rsp_live = i_imem_rsp_valid && (drop == '0) && !i_redirect_valid;
    assign buf_pop  = o_instr_valid && i_instr_ready;
    assign buf_in   = '{pc: pend_pc, instr: i_imem_rsp_data};

    assign o_imem_req_valid = !i_rst && !halted && (used < (CW + 1)'(FIFO_DEPTH));
    assign o_imem_addr      = pc;
    assign o_instr_valid    = (cnt != '0);
    assign o_instr          = buf_head.instr;
    assign o_opcode         = buf_head.instr[6:0];
    assign o_pc             = buf_head.pc;

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(logic [31:0])) u_pend (
        .clk   (i_clk),
        .rst   (i_rst),
        .flush (i_redirect_valid),
        .push  (req_fire),
        .data  (pc),
        .pop   (rsp_live),
        .head  (pend_pc),
        .count (pend_cnt)
    );

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(fetch_entry_t)) u_buf (
        .clk   (i_clk),
        .rst   (i_rst),
        .flush (i_redirect_valid),
        .push  (rsp_live),
        .data  (buf_in),
        .pop   (buf_pop),
        .head  (buf_head),
        .count (cnt)
    );

    // On redirect every request still in flight after this edge becomes a squash.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc   <= RESET_PC;
            drop <= '0;
        end else if (i_redirect_valid) begin
            pc   <= i_redirect_pc & ~32'h3;
            drop <= outs + CW'(req_fire) - CW'(i_imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc <= pc + PC_STEP;
            end
            if (i_imem_rsp_valid && (drop != '0)) begin
                drop <= drop - CW'(1);
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            halted        <= 1'b0;
            o_fetch_fault <= 1'b0;
        end else if (i_redirect_valid) begin
            halted        <= |i_redirect_pc[1:0];
            o_fetch_fault <= |i_redirect_pc[1:0];
        end
    end
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        redir_v;
    logic [31:0] redir_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [31:0] pc;
    logic        fault;

    logic        w_valid;
    logic [31:0] w_addr;
    logic        w_zero;
    logic [31:0] w_zero32;
    logic        w_ivalid;
    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [31:0] w_pc;
    logic        w_fault;

    logic        auto_mem;
    logic        man_v;
    logic [31:0] man_d;
    logic        mem_hs;
    logic [31:0] mem_addr;

    int total;
    int bad;

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs [22];

    instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .o_imem_req_valid (req_valid),
        .i_imem_req_ready (req_ready),
        .o_imem_addr      (addr),
        .i_imem_rsp_valid (rsp_valid),
        .i_imem_rsp_data  (rsp_data),
        .i_redirect_valid (redir_v),
        .i_redirect_pc    (redir_pc),
        .o_instr_valid    (instr_valid),
        .i_instr_ready    (instr_ready),
        .o_instr          (instr),
        .o_opcode         (opcode),
        .o_pc             (pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .o_fetch_fault    (fault)
`endif
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_wrap (
        .i_clk            (clk),
        .i_rst            (rst),
        .o_imem_req_valid (w_valid),
        .i_imem_req_ready (req_ready),
        .o_imem_addr      (w_addr),
        .i_imem_rsp_valid (w_zero),
        .i_imem_rsp_data  (w_zero32),
        .i_redirect_valid (w_zero),
        .i_redirect_pc    (w_zero32),
        .o_instr_valid    (w_ivalid),
        .i_instr_ready    (w_zero),
        .o_instr          (w_instr),
        .o_opcode         (w_opcode),
        .o_pc             (w_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .o_fetch_fault    (w_fault)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : {a[24:0], 7'h13};
    endfunction

    // Memory: latency-1 responder in auto mode, otherwise replays man_v/man_d.
    initial begin
        forever begin
            @(negedge clk);
            mem_hs   = req_valid && req_ready;
            mem_addr = addr;
            @(posedge clk);
            #2;
            if (auto_mem) begin
                rsp_valid = mem_hs;
                rsp_data  = mem_hs ? mem_word(mem_addr) : 32'h0;
            end else begin
                rsp_valid = man_v;
                rsp_data  = man_d;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        auto_mem    = 1'b0;
        man_v       = 1'b0;
        man_d       = 32'h0;
        redir_v     = 1'b0;
        redir_pc    = 32'h0;
        instr_ready = 1'b0;
        req_ready   = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_req_valid", {31'h0, req_valid}, 32'h0);
        chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_opcode", {25'h0, opcode}, 32'h0);
        chk("rst_pc", pc, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("rst_fault", {31'h0, fault}, 32'h0);
`endif
        tick();
        rst = 1'b0;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        w_zero   = 1'b0;
        w_zero32 = 32'h0;
        rsp_valid = 1'b0;
        rsp_data  = 32'h0;

        vecs[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[2]  = '{1'b1, 1'b0, 32'h08, 1'b1, 32'h00};
        vecs[3]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
        vecs[4]  = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
        vecs[5]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
        vecs[6]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
        vecs[7]  = '{1'b0, 1'b1, 32'h14, 1'b0, 32'h00};
        for (int i = 8; i <= 16; i++) begin
            vecs[i] = '{1'b0, 1'b0, 32'h18, 1'b1, 32'h10};
        end
        vecs[17] = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
        vecs[18] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h14};
        vecs[19] = '{1'b1, 1'b1, 32'h1C, 1'b0, 32'h00};
        vecs[20] = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h18};
        vecs[21] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h1C};

        // Streaming with latency-1 memory, including a 10-cycle decode stall.
        do_reset();
        auto_mem = 1'b1;
        for (int i = 0; i < 22; i++) begin
            logic [31:0] exp_ins;
            instr_ready = vecs[i].rdy;
            exp_ins = vecs[i].iv ? mem_word(vecs[i].pc) : 32'h0;
            @(negedge clk);
            chk($sformatf("v%0d_req_valid", i), {31'h0, req_valid}, {31'h0, vecs[i].rv});
            chk($sformatf("v%0d_addr", i), addr, vecs[i].addr);
            chk($sformatf("v%0d_instr_valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].iv});
            chk($sformatf("v%0d_pc", i), pc, vecs[i].pc);
            chk($sformatf("v%0d_instr", i), instr, exp_ins);
            chk($sformatf("v%0d_opcode", i), {25'h0, opcode}, {25'h0, exp_ins[6:0]});
            tick();
        end

        // Redirect to 0x100 with two requests outstanding.
        do_reset();
        instr_ready = 1'b1;
        @(negedge clk);
        chk("s2_addr0", addr, 32'h0);
        tick();
        @(negedge clk);
        chk("s2_addr1", addr, 32'h4);
        tick();
        man_v = 1'b1; man_d = mem_word(32'h0); redir_v = 1'b1; redir_pc = 32'h100;
        @(negedge clk);
        chk("s2_credit_hold", {31'h0, req_valid}, 32'h0);
        tick();
        redir_v = 1'b0; man_d = mem_word(32'h4);
        @(negedge clk);
        chk("s2_new_req_valid", {31'h0, req_valid}, 32'h1);
        chk("s2_new_req_addr", addr, 32'h100);
        chk("s2_no_stale_a", {31'h0, instr_valid}, 32'h0);
        tick();
        man_d = mem_word(32'h100);
        @(negedge clk);
        chk("s2_no_stale_b", {31'h0, instr_valid}, 32'h0);
        chk("s2_next_addr", addr, 32'h104);
        tick();
        man_v = 1'b0;
        @(negedge clk);
        chk("s2_out_valid", {31'h0, instr_valid}, 32'h1);
        chk("s2_out_pc", pc, 32'h100);
        chk("s2_out_instr", instr, mem_word(32'h100));
        tick();

        // Redirect coinciding with a response and a request handshake.
        do_reset();
        instr_ready = 1'b1;
        @(negedge clk);
        chk("s3_addr0", addr, 32'h0);
        tick();
        man_v = 1'b1; man_d = mem_word(32'h0); redir_v = 1'b1; redir_pc = 32'h200;
        @(negedge clk);
        chk("s3_hs_valid", {31'h0, req_valid}, 32'h1);
        chk("s3_hs_addr", addr, 32'h4);
        tick();
        redir_v = 1'b0; man_d = mem_word(32'h4);
        @(negedge clk);
        chk("s3_new_addr", addr, 32'h200);
        chk("s3_no_stale_a", {31'h0, instr_valid}, 32'h0);
        tick();
        man_d = mem_word(32'h200);
        @(negedge clk);
        chk("s3_no_stale_b", {31'h0, instr_valid}, 32'h0);
        chk("s3_next_addr", addr, 32'h204);
        tick();
        man_v = 1'b0;
        @(negedge clk);
        chk("s3_out_valid", {31'h0, instr_valid}, 32'h1);
        chk("s3_out_pc", pc, 32'h200);
        chk("s3_out_instr", instr, mem_word(32'h200));
        tick();

        // Misaligned redirect, then an aligned one.
        do_reset();
        req_ready = 1'b0;
        redir_v = 1'b1; redir_pc = 32'h102;
        tick();
        redir_v = 1'b0;
        @(negedge clk);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("s4_halt_valid", {31'h0, req_valid}, 32'h0);
        chk("s4_fault_set", {31'h0, fault}, 32'h1);
`else
        chk("s4_mask_valid", {31'h0, req_valid}, 32'h1);
        chk("s4_mask_addr", addr, 32'h100);
`endif
        tick();
        redir_v = 1'b1; redir_pc = 32'h200;
        tick();
        redir_v = 1'b0;
        @(negedge clk);
        chk("s4_resume_valid", {31'h0, req_valid}, 32'h1);
        chk("s4_resume_addr", addr, 32'h200);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("s4_fault_clear", {31'h0, fault}, 32'h0);
`endif
        tick();

        // PC wrap on the second instance (no responses ever returned).
        do_reset();
        @(negedge clk);
        chk("wrap_valid0", {31'h0, w_valid}, 32'h1);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        tick();
        @(negedge clk);
        chk("wrap_valid1", {31'h0, w_valid}, 32'h1);
        chk("wrap_addr1", w_addr, 32'h0000_0000);
        tick();
        @(negedge clk);
        chk("wrap_credit_hold", {31'h0, w_valid}, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
